dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters (port 0: load/store unit,

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between two requesters sharing a single-port data memory.
// One transaction is in flight at a time. Each access waits out a fixed latency
// model, performs a single memory cycle and then returns a one-cycle response.
//
// Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready.
// Ready is combinational, asserted only in IDLE for the granted port. A requester
// holds valid and its fields stable until ready. Dropping valid earlier withdraws
// the request with no side effect. Responses are single-cycle pulses with no
// back-pressure.
module dmem_arbiter #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Counter only ever holds values up to LATENCY-1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_last_q;
  logic          id_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   resp0_rdata_q;
  logic [31:0]   resp1_rdata_q;

  logic          gnt_valid;
  logic          gnt_id;

  // Grant selection: the lone valid port, or the port that did not win last time.
  // Gated by reset so ready stays low while reset is held.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (reset && (state_q == S_IDLE)) begin
      if (req0_valid && req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~rr_last_q;
      end else if (req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_valid && !gnt_id;
  assign req1_ready = gnt_valid &&  gnt_id;

  // Next-state logic for the access sequencer and its latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch on acceptance, round-robin pointer, and per-port response data
  // captured at the close of the ACCESS cycle (stores return zero).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q     <= 1'b1;
      id_q          <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      if (gnt_valid) begin
        rr_last_q <= gnt_id;
        id_q      <= gnt_id;
        write_q   <= gnt_id ? req1_write : req0_write;
        addr_q    <= gnt_id ? req1_addr  : req0_addr;
        wdata_q   <= gnt_id ? req1_wdata : req0_wdata;
      end
      if (state_q == S_ACCESS) begin
        if (id_q) begin
          resp1_rdata_q <= write_q ? 32'h0 : mem_rdata;
        end else begin
          resp0_rdata_q <= write_q ? 32'h0 : mem_rdata;
        end
      end
    end
  end

  // Memory strobes decode purely from registered state, so they cannot glitch.
  assign mem_addr    = (state_q != S_IDLE) ? addr_q  : 32'h0;
  assign mem_data    = (state_q != S_IDLE) ? wdata_q : 32'h0;
  assign mem_write   = (state_q == S_ACCESS) &&  write_q;
  assign mem_read    = (state_q == S_ACCESS) && !write_q;

  assign resp0_valid = (state_q == S_RESP) && !id_q;
  assign resp1_valid = (state_q == S_RESP) &&  id_q;
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic on a
// LATENCY=5 instance, checked against a transaction-timing reference model,
// and a short directed check of a LATENCY=1 instance.
module tb_dmem_arbiter;

  localparam int LAT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (LATENCY=5) ----------------
  logic        req0_valid = 0, req0_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0;
  logic        req1_valid = 0, req1_write = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, resp0_valid, req1_ready, resp1_valid;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic        mem_write, mem_read;
  logic [1:0]  dbg_state;

  dmem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  logic [31:0] mem1 [0:1023];
  assign mem_rdata = mem1[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= 32'h0;
    end else if (mem_write) begin
      mem1[mem_addr[9:0]] <= mem_data;
    end
  end

  // ---------------- second DUT (LATENCY=1) ----------------
  logic        b_valid = 0, b_write = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        z1 = 1'b0;
  logic [31:0] z32 = 32'h0;
  logic        b_ready, b_resp_valid, b1_ready, b1_resp_valid;
  logic [31:0] b_resp_rdata, b1_resp_rdata;
  logic [31:0] b_mem_addr, b_mem_data, b_mem_rdata;
  logic        b_mem_write, b_mem_read;
  logic [1:0]  b_dbg;

  dmem_arbiter #(.LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(b_valid), .req0_write(b_write), .req0_addr(b_addr),
    .req0_wdata(b_wdata), .req0_ready(b_ready), .resp0_valid(b_resp_valid),
    .resp0_rdata(b_resp_rdata),
    .req1_valid(z1), .req1_write(z1), .req1_addr(z32),
    .req1_wdata(z32), .req1_ready(b1_ready), .resp1_valid(b1_resp_valid),
    .resp1_rdata(b1_resp_rdata),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_write(b_mem_write),
    .mem_read(b_mem_read), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg)
  );

  logic [31:0] mem2 [0:1023];
  assign b_mem_rdata = mem2[b_mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem2[i] <= (i == 16) ? 32'hA5A50001 : 32'h0;
    end else if (b_mem_write) begin
      mem2[b_mem_addr[9:0]] <= b_mem_data;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Works in transaction terms: an accepted request at cycle t owns the memory
  // window t+1..t+LAT+1, strobes the memory at t+LAT, responds at t+LAT+1 and
  // frees the arbiter at t+LAT+2.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q[$];
  int          acc_id_q[$];
  int          acc_cyc_q[$];
  int          cyc = 0;
  bit          busy = 0;
  int          t0 = 0;
  int          nfree = 0;
  bit          last = 1;
  bit          cur_id, cur_w;
  logic [31:0] cur_a, cur_d;
  logic [31:0] hold0 = 0, hold1 = 0;
  bit          acc0 = 0, acc1 = 0;
  int          g;
  bit          in_win, ev0, ev1, ew, er;
  logic [31:0] rd;
  int          last_wr_cyc = -1, last_r0_cyc = -1;

  initial for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      busy  = 0;
      last  = 1;
      hold0 = 0;
      hold1 = 0;
      exp_q.delete();
    end else begin
      if (mem_write)   last_wr_cyc = cyc;
      if (resp0_valid) last_r0_cyc = cyc;
      if (busy && cyc >= nfree) busy = 0;
      g = -1;
      if (!busy) begin
        if (req0_valid && req1_valid) g = last ? 0 : 1;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      check_eq("ready0", 32'(req0_ready), 32'(g == 0));
      check_eq("ready1", 32'(req1_ready), 32'(g == 1));
      if (g >= 0) begin
        busy   = 1;
        t0     = cyc;
        nfree  = cyc + LAT + 2;
        last   = (g == 1);
        cur_id = (g == 1);
        cur_w  = (g == 1) ? req1_write : req0_write;
        cur_a  = (g == 1) ? req1_addr  : req0_addr;
        cur_d  = (g == 1) ? req1_wdata : req0_wdata;
        if (g == 1) acc1 = 1; else acc0 = 1;
        acc_id_q.push_back(g);
        acc_cyc_q.push_back(cyc);
      end
      in_win = busy && (cyc > t0) && (cyc <= t0 + LAT + 1);
      ew = busy && (cyc == t0 + LAT) && cur_w;
      er = busy && (cyc == t0 + LAT) && !cur_w;
      if (busy && cyc == t0 + LAT) begin
        if (cur_w) ref_mem[cur_a[9:0]] = cur_d;
        exp_q.push_back(cur_w ? 32'h0 : ref_mem[cur_a[9:0]]);
      end
      ev0 = 0;
      ev1 = 0;
      if (busy && cyc == t0 + LAT + 1 && exp_q.size() > 0) begin
        rd = exp_q.pop_front();
        if (cur_id) begin ev1 = 1; hold1 = rd; end
        else        begin ev0 = 1; hold0 = rd; end
      end
      check_eq("mem_addr",    mem_addr,  in_win ? cur_a : 32'h0);
      check_eq("mem_data",    mem_data,  in_win ? cur_d : 32'h0);
      check_eq("mem_write",   32'(mem_write),   32'(ew));
      check_eq("mem_read",    32'(mem_read),    32'(er));
      check_eq("resp0_valid", 32'(resp0_valid), 32'(ev0));
      check_eq("resp1_valid", 32'(resp1_valid), 32'(ev1));
      check_eq("resp0_rdata", resp0_rdata, hold0);
      check_eq("resp1_rdata", resp1_rdata, hold1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Present a request and hold it until accepted (bounded), then drop valid.
  task automatic send(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    if (p == 0) acc0 = 0; else acc1 = 0;
    set_req(p, 1'b1, w, a, d);
    while (!((p == 0) ? acc0 : acc1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("send_ack", 32'(n < 50), 32'd1);
    if (p == 0) acc0 = 0; else acc1 = 0;
    set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int cnt);
    int n = 0;
    while (acc_id_q.size() < cnt && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("acc_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic rand_step();
    if (req0_valid) begin
      if (acc0) begin req0_valid = 0; acc0 = 0; end
      else if ($urandom_range(0, 19) == 0) req0_valid = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      set_req(0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    end
    if (req1_valid) begin
      if (acc1) begin req1_valid = 0; acc1 = 0; end
      else if ($urandom_range(0, 19) == 0) req1_valid = 0;
    end else if ($urandom_range(0, 2) == 0) begin
      set_req(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
    end
  endtask

  // ---------------- stimulus ----------------
  int exp_ids [4] = '{0, 1, 0, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_memaddr", mem_addr, 32'h0);
    check_eq("rst_dbg", 32'(dbg_state), 32'd0);
    reset   = 1'b1;
    mem_clr = 1'b0;
    idle_cycles(2);

    // both ports request loads continuously: 0,1,0,1 spaced LAT+2 apart
    acc_id_q.delete(); acc_cyc_q.delete();
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_acc(4);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < acc_id_q.size()) check_eq("rr_grant", 32'(acc_id_q[i]), 32'(exp_ids[i]));
      if (i > 0 && i < acc_cyc_q.size())
        check_eq("rr_spacing", 32'(acc_cyc_q[i] - acc_cyc_q[i-1]), 32'd7);
    end
    idle_cycles(10);

    // port 0 store then load at 0x10, timing of strobe and response
    acc_id_q.delete(); acc_cyc_q.delete();
    send(0, 1'b1, 32'h10, 32'hDEADBEEF);
    idle_cycles(8);
    check_eq("c1_wr_lat", 32'(last_wr_cyc - acc_cyc_q[0]), 32'd5);
    check_eq("c1_resp_lat", 32'(last_r0_cyc - acc_cyc_q[0]), 32'd6);
    check_eq("c1_store_rdata", resp0_rdata, 32'h0);
    send(0, 1'b0, 32'h10, 32'h0);
    idle_cycles(8);
    check_eq("c1_load_rdata", resp0_rdata, 32'hDEADBEEF);

    // cross-port read-after-write
    send(1, 1'b1, 32'h4, 32'h12345678);
    idle_cycles(8);
    send(0, 1'b0, 32'h4, 32'h0);
    idle_cycles(8);
    check_eq("c6_load_rdata", resp0_rdata, 32'h12345678);
    check_eq("c6_store_rdata", resp1_rdata, 32'h0);

    // port 0 request arrives during port 1's wait: served at next IDLE
    acc_id_q.delete(); acc_cyc_q.delete();
    send(1, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    send(0, 1'b0, 32'h14, 32'h0);
    check_eq("c3_first", 32'(acc_id_q[0]), 32'd1);
    if (acc_id_q.size() > 1) begin
      check_eq("c3_second", 32'(acc_id_q[1]), 32'd0);
      check_eq("c3_gap", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'd7);
    end else begin
      check_eq("c3_second_seen", 32'(acc_id_q.size()), 32'd2);
    end
    idle_cycles(10);

    // reset during the wait of a port 0 store
    send(0, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h34, 32'h0);
    #1 reset = 1'b0;
    #1;
    check_eq("c4_ready0", 32'(req0_ready), 32'd0);
    check_eq("c4_ready1", 32'(req1_ready), 32'd0);
    check_eq("c4_mem_addr", mem_addr, 32'h0);
    check_eq("c4_mem_data", mem_data, 32'h0);
    check_eq("c4_mem_write", 32'(mem_write), 32'd0);
    check_eq("c4_mem_read", 32'(mem_read), 32'd0);
    check_eq("c4_resp0", 32'(resp0_valid), 32'd0);
    check_eq("c4_resp1", 32'(resp1_valid), 32'd0);
    check_eq("c4_rdata0", resp0_rdata, 32'h0);
    check_eq("c4_rdata1", resp1_rdata, 32'h0);
    idle_cycles(6);
    check_eq("c4_mem_unchanged", mem1[32], 32'h0);
    acc_id_q.delete(); acc_cyc_q.delete();
    acc0 = 0; acc1 = 0;
    reset = 1'b1;
    wait_acc(1);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    acc0 = 0;
    check_eq("c4_first_grant", 32'(acc_id_q[0]), 32'd0);
    idle_cycles(10);
    check_eq("c4_mem_after", mem1[32], 32'h0);

    // randomized traffic
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 1500; i++) begin
      rand_step();
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle_cycles(10);

    // LATENCY=1 instance: no wait state
    b_valid = 1; b_write = 0; b_addr = 32'h10;
    @(negedge clk);
    check_eq("c5_ready", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    check_eq("c5_read", 32'(b_mem_read), 32'd1);
    check_eq("c5_write", 32'(b_mem_write), 32'd0);
    check_eq("c5_resp_early", 32'(b_resp_valid), 32'd0);
    check_eq("c5_addr", b_mem_addr, 32'h10);
    check_eq("c5_no_wait", 32'(b_dbg == 2'd1), 32'd0);
    @(negedge clk);
    check_eq("c5_resp", 32'(b_resp_valid), 32'd1);
    check_eq("c5_rdata", b_resp_rdata, 32'hA5A50001);
    check_eq("c5_read_off", 32'(b_mem_read), 32'd0);
    check_eq("c5_resp1", 32'(b1_resp_valid), 32'd0);
    @(negedge clk);
    check_eq("c5_resp_off", 32'(b_resp_valid), 32'd0);
    check_eq("c5_rdata_hold", b_resp_rdata, 32'hA5A50001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
